// File: rtl/adder4_seq.sv
// adder4_seq: multi-nibble addition sequencer driving one shared external adder4.
// Each nibble takes two adder passes: first a_q[n] + b_q[n], then the partial sum
// plus the carry from the previous nibble. This folds the carry in without a
// carry-in pin on the adder.
module adder4_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    input  logic [3:0]           add_s,
    input  logic                 add_c4
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_AB = 2'd1,
        ADD_C  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [3:0]       tmp;
    logic             c_pass;
    logic             carry;
    logic [IDX_W-1:0] idx;

    // The adder operands are a mux of registered values, so the adder round trip fits in one cycle.
    always_comb begin
        // NOTE: assign defaults before the case so that no path leaves a value unassigned, which would infer a latch.
        add_a = '0;
        add_b = '0;
        case (state)
            ADD_AB: begin
                add_a = a_q[{idx, 2'b00} +: 4];
                add_b = b_q[{idx, 2'b00} +: 4];
            end
            ADD_C: begin
                add_a = tmp;
                add_b = {3'b000, carry};
            end
            default: ;
        endcase
    end

    // Sequencer FSM. The handshake and busy flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this block uses non-blocking assignments only, so every register updates from pre-edge values.
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            tmp       <= '0;
            c_pass    <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        idx      <= '0;
                        carry    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ADD_AB;
                    end
                end
                ADD_AB: begin
                    tmp    <= add_s;
                    c_pass <= add_c4;
                    state  <= ADD_C;
                end
                ADD_C: begin
                    sum_q[{idx, 2'b00} +: 4] <= add_s;
                    // At most one of these can be set: 15+15 leaves S=14, and 14+1 cannot carry.
                    carry <= c_pass | add_c4;
                    if (idx == LAST_IDX) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ADD_AB;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = carry;

endmodule

// File: tb/tb_adder4_seq.sv
// Testbench for adder4_seq. It models the external adder4 and uses a queue-based scoreboard
// for the NIBBLES=4 build, plus directed checks on a NIBBLES=1 build.
module tb_adder4_seq;

    logic        clk;
    logic        rst_n;

    // NIBBLES=4 instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_s;
    logic        add_c4;

    // NIBBLES=1 instance
    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  op_a1;
    logic [3:0]  op_b1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  sum1;
    logic        cout1;
    logic        busy1;
    logic [3:0]  add_a1;
    logic [3:0]  add_b1;
    logic [3:0]  add_s1;
    logic        add_c41;

    int          checks;
    int          failures;
    logic [16:0] exp_q[$];
    logic        hold_low;
    logic        rand_mode;
    logic        ab_c4;
    logic        phase;

    adder4_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .busy(busy), .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c4(add_c4)
    );

    adder4_seq #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .op_a(op_a1), .op_b(op_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
        .busy(busy1), .add_a(add_a1), .add_b(add_b1), .add_s(add_s1), .add_c4(add_c41)
    );

    // External combinational adder4 models, no carry-in
    assign {add_c4, add_s}   = {1'b0, add_a} + {1'b0, add_b};
    assign {add_c41, add_s1} = {1'b0, add_a1} + {1'b0, add_b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a result is consumed on each cycle where valid&ready holds
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sum", {16'd0, sum}, {16'd0, e[15:0]});
                check("cout", {31'd0, cout}, {31'd0, e[16]});
            end
        end
    end

    // Double-carry watch: ADD_AB and ADD_C passes alternate while busy
    always @(negedge clk) begin
        if (!rst_n || !busy) begin
            phase = 1'b0;
        end else if (!phase) begin
            ab_c4 = add_c4;
            phase = 1'b1;
        end else begin
            check("double_carry", {31'd0, ab_c4 & add_c4}, 32'd0);
            phase = 1'b0;
        end
    end

    // out_ready driver: held high, held low, or random, changing away from the edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_low)       out_ready = 1'b0;
            else if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            else                out_ready = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one operand pair; returns at accept edge + 1
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", {31'd0, (exp_q.size() != 0 || out_valid)}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, {16'd0, sum}, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check({tag, "_add_a"}, {28'd0, add_a}, 32'd0);
        check({tag, "_add_b"}, {28'd0, add_b}, 32'd0);
    endtask

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        hold_low   = 1'b0;
        rand_mode  = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        in_valid1  = 1'b0;
        op_a1      = '0;
        op_b1      = '0;
        out_ready1 = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_in_ready1", {31'd0, in_ready1}, 32'd1);
        check("reset_out_valid1", {31'd0, out_valid1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // NIBBLES=1: 0xF + 0x1 -> 0x0, cout=1 two cycles after accept
        in_valid1 = 1'b1;
        op_a1     = 4'hF;
        op_b1     = 4'h1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("n1_busy", {31'd0, busy1}, 32'd1);
        check("n1_early", {31'd0, out_valid1}, 32'd0);
        @(posedge clk);
        #1;
        check("n1_early2", {31'd0, out_valid1}, 32'd0);
        @(posedge clk);
        #1;
        check("n1_valid", {31'd0, out_valid1}, 32'd1);
        check("n1_sum", {28'd0, sum1}, 32'h0);
        check("n1_cout", {31'd0, cout1}, 32'd1);

        // Latency: out_valid rises exactly 8 edges after the accept edge
        send(16'h1234, 16'h4321, 17'h05555);
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("lat_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_on", {31'd0, out_valid}, 32'd1);
        drain();

        // Carry ripple through the ADD_C passes
        send(16'hFFFF, 16'h0001, 17'h10000);
        send(16'h0FFF, 16'h0001, 17'h01000);
        drain();

        // Backpressure: out_ready low for 5 cycles, a stray in_valid pulse is ignored
        hold_low = 1'b1;
        send(16'h8000, 16'h8000, 17'h10000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, sum}, 32'h0);
            check("bp_cout", {31'd0, cout}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (k == 1) begin
                op_a     = 16'h1111;
                op_b     = 16'h1111;
                in_valid = 1'b1;
            end
            if (k == 2) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        hold_low = 1'b0;
        drain();

        // Async reset in ADD_C of nibble 2: accept edge E0, ADD_C idx2 follows edge E0+5
        send(16'h1111, 16'h2222, 17'h03333);
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'h0001, 16'h0001, 17'h00002);
        drain();

        // Back-to-back random pairs with random out_ready stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            send(a, b, {1'b0, a} + {1'b0, b});
        end
        rand_mode = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder4_seq.md
# adder4_seq

Multi-nibble addition sequencer for the shared 4-bit adder (`adder4`: ports A, B, S, C4, no carry-in). Accepts a NIBBLES×4-bit operand pair over a valid/ready handshake. Drives the external combinational adder one nibble at a time, using two adder passes per nibble to fold in the inter-nibble carry. Returns the full-width sum and carry-out over a second valid/ready handshake. Sits between the top-level IO wrapper and one `adder4` instance, which it owns exclusively.

## Interface
- NIBBLES, 4, operand width in nibbles (≥1); W = 4*NIBBLES
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- op_a  in  W  operand A
- op_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result, (op_a + op_b) mod 2^W
- cout  out  1  carry out of bit W-1
- busy  out  1  high in ADD_AB or ADD_C
- add_a  out  4  to adder A
- add_b  out  4  to adder B
- add_s  in  4  from adder S
- add_c4  in  1  from adder C4

## Operation
- States: IDLE, ADD_AB, ADD_C, DONE. Registers: a_q, b_q (W), sum_q (W), tmp (4), c_pass (1), carry (1), idx (clog2(NIBBLES), min 1 bit).
- IDLE:
  - in_ready=1.
  - On in_valid: latch op_a/op_b, set idx=0, carry=0, go to ADD_AB.
- ADD_AB:
  - add_a=a_q[idx], add_b=b_q[idx].
  - Capture tmp=add_s and c_pass=add_c4, go to ADD_C.
- ADD_C:
  - add_a=tmp, add_b={3'b000,carry}.
  - Write sum_q[idx]=add_s; set carry=c_pass|add_c4.
  - c_pass and add_c4 are never both 1 (max 15+15=30 leaves S=14, +1 ≤15). The bench flags the case where both are 1 as an assertion.
  - If idx==NIBBLES-1, go to DONE; else idx+1, go to ADD_AB.
- DONE:
  - out_valid=1; sum=sum_q, cout=carry are held stable.
  - On out_ready, go to IDLE.
- add_a/add_b are 0 in IDLE and DONE.
- busy = (state==ADD_AB)|(state==ADD_C).
- in_valid while not IDLE is ignored; the source must hold the operands until the handshake completes.
- sum/cout keep the last result after leaving DONE, until the next result is written nibble by nibble. The consumer only samples them when out_valid=1.

## Timing
- Reset (async assert, sync-to-clk deassert is the wrapper's job):
  - state=IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - sum=0, cout=0, add_a=0, add_b=0.
  - All internal registers are cleared.
- Latency: accept edge E0 → out_valid high after edge E0+2*NIBBLES (8 cycles at default). Fixed, independent of data.
- Throughput: one operation per 2*NIBBLES+2 cycles with out_ready held high. There is no overlap: in_ready is low from E0 until the edge after the out_valid&out_ready handshake.
- Handshakes complete on the edge where valid&ready=1.
  - out_ready low: DONE is held indefinitely with outputs stable.
  - in_ready is registered (state-decoded), with no combinational path from in_valid.
- The adder path is combinational within one cycle: add_a/add_b come from registers, and add_s/add_c4 are captured on the same edge.
- Reset mid-operation: immediately returns to IDLE, the partial result is discarded, out_valid=0. No output ever presents a partial sum with out_valid=1.

## Test plan
- 0x1234 + 0x4321 (NIBBLES=4) → sum=0x5555, cout=0; out_valid exactly 8 cycles after the accept edge.
- 0xFFFF + 0x0001 → sum=0x0000, cout=1. Then 0x0FFF + 0x0001 → sum=0x1000, cout=0, proving the carry ripples through the ADD_C passes.
- Backpressure:
  - 0x8000 + 0x8000 with out_ready held low 5 cycles → out_valid stays 1, sum=0x0000, cout=1 stable throughout.
  - in_ready stays 0 and a new in_valid pulse is ignored until the handshake.
- Reset asserted mid-ADD_C of nibble 2:
  - async: all outputs are at reset values before the next clk edge.
  - The next op 0x0001+0x0001 → 0x0002, cout=0.
- NIBBLES=1 build: 0xF + 0x1 → sum=0x0, cout=1 at 2 cycles latency.
- Back-to-back: 200 random pairs with random out_ready stalls vs a reference model → all sums/carries match, adder C4-double-carry assertion never fires.
